io_port_responder: RTL and testbench

//  Memory-mapped I/O responder on the CPU's RAM-style bus (addr/rd/wr/data),

---
 rtl/io_port_responder.sv | 133 +++++++++++++
 tb/tb_io_port_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: answers RAM-style CPU bus accesses from an
// RX FIFO (external producer) and a TX FIFO (external consumer).
module io_port_responder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] addr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       rd_valid,
    input  logic [7:0] ext_rx_data,
    input  logic       ext_rx_valid,
    output logic       ext_rx_ready,
    output logic [7:0] ext_tx_data,
    output logic       ext_tx_valid,
    input  logic       ext_tx_ready,
    output logic       irq
);
    localparam logic [3:0] FULL_CNT = 4'(DEPTH);

    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    rx_mem_d [DEPTH];
    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    tx_mem_d [DEPTH];
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [3:0]    rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rx_unf_q, rx_unf_d, tx_ovf_q, tx_ovf_d;
    logic          irq_q, irq_d;

    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rd_acc, rx_push, rx_pop, tx_push, tx_pop;
    logic set_unf, set_ovf, clr_unf, clr_ovf;

    assign rx_empty = (rx_cnt_q == 4'd0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == 4'd0);
    assign tx_full  = (tx_cnt_q == FULL_CNT);

    // A write in the same cycle as a read wins; the read is dropped entirely.
    assign rd_acc  = rd & ~wr;
    assign rx_pop  = rd_acc & (addr == 4'h0) & ~rx_empty;
    assign set_unf = rd_acc & (addr == 4'h0) & rx_empty;
    assign rx_push = ext_rx_valid & ext_rx_ready;
    assign tx_push = wr & (addr == 4'h1) & ~tx_full;
    assign set_ovf = wr & (addr == 4'h1) & tx_full;
    assign tx_pop  = ext_tx_valid & ext_tx_ready;
    assign clr_ovf = wr & (addr == 4'h2) & data_in[3];
    assign clr_unf = wr & (addr == 4'h2) & data_in[2];

    always_comb begin
        rx_mem_d   = rx_mem_q;
        tx_mem_d   = tx_mem_q;
        rx_wp_d    = rx_wp_q;
        rx_rp_d    = rx_rp_q;
        tx_wp_d    = tx_wp_q;
        tx_rp_d    = tx_rp_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        if (rd_acc) begin
            rd_valid_d = 1'b1;
            case (addr)
                4'h0:    data_out_d = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
                4'h2:    data_out_d = {4'b0000, tx_ovf_q, rx_unf_q, tx_full, rx_empty};
                4'h3:    data_out_d = {rx_cnt_q, tx_cnt_q};
                default: data_out_d = 8'h00;
            endcase
        end
        if (rx_push) begin
            rx_mem_d[rx_wp_q] = ext_rx_data;
            rx_wp_d           = rx_wp_q + AW'(1);
        end
        if (rx_pop) rx_rp_d = rx_rp_q + AW'(1);
        if (tx_push) begin
            tx_mem_d[tx_wp_q] = data_in;
            tx_wp_d           = tx_wp_q + AW'(1);
        end
        if (tx_pop) tx_rp_d = tx_rp_q + AW'(1);
        rx_cnt_d = rx_cnt_q + {3'b000, rx_push} - {3'b000, rx_pop};
        tx_cnt_d = tx_cnt_q + {3'b000, tx_push} - {3'b000, tx_pop};
        // Set has priority over a same-cycle W1C clear.
        rx_unf_d = set_unf | (rx_unf_q & ~clr_unf);
        tx_ovf_d = set_ovf | (tx_ovf_q & ~clr_ovf);
        irq_d    = ~rx_empty | rx_unf_q | tx_ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rx_mem_q[i] <= 8'h00;
                tx_mem_q[i] <= 8'h00;
            end
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_cnt_q   <= 4'd0;
            tx_cnt_q   <= 4'd0;
            data_out_q <= 8'h00;
            rd_valid_q <= 1'b0;
            rx_unf_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rx_mem_q   <= rx_mem_d;
            tx_mem_q   <= tx_mem_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            rx_unf_q   <= rx_unf_d;
            tx_ovf_q   <= tx_ovf_d;
            irq_q      <= irq_d;
        end
    end

    assign data_out     = data_out_q;
    assign rd_valid     = rd_valid_q;
    assign irq          = irq_q;
    assign ext_rx_ready = ~rx_full & ~rst;
    assign ext_tx_valid = ~tx_empty;
    assign ext_tx_data  = tx_mem_q[tx_rp_q];
endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: queue-based reference model checked every
// cycle, plus directed register accesses with literal expectations.
module tb_io_port_responder;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] addr = 4'h0;
    logic       rd = 1'b0, wr = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       rd_valid;
    logic [7:0] ext_rx_data = 8'h00;
    logic       ext_rx_valid = 1'b0;
    logic       ext_rx_ready;
    logic [7:0] ext_tx_data;
    logic       ext_tx_valid;
    logic       ext_tx_ready = 1'b0;
    logic       irq;

    int n_chk = 0;
    int n_fail = 0;

    io_port_responder #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
        .data_out(data_out), .rd_valid(rd_valid),
        .ext_rx_data(ext_rx_data), .ext_rx_valid(ext_rx_valid), .ext_rx_ready(ext_rx_ready),
        .ext_tx_data(ext_tx_data), .ext_tx_valid(ext_tx_valid), .ext_tx_ready(ext_tx_ready),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, flags as bits.
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit         m_unf, m_ovf, m_rv, m_irq;
    logic [7:0] m_dout;

    task automatic model_step();
        int rx_n = rxq.size();
        int tx_n = txq.size();
        bit do_rd = rd && !wr;
        bit set_unf = 0, set_ovf = 0, clr_unf = 0, clr_ovf = 0;
        bit rx_pop = 0, tx_push = 0;
        bit irq_next;
        if (rst) begin
            rxq.delete(); txq.delete();
            m_unf = 0; m_ovf = 0; m_rv = 0; m_irq = 0; m_dout = 8'h00;
            return;
        end
        irq_next = (rx_n != 0) || m_unf || m_ovf;
        m_rv = do_rd;
        if (do_rd) begin
            if (addr == 4'h0) begin
                if (rx_n == 0) begin m_dout = 8'h00; set_unf = 1; end
                else begin m_dout = rxq[0]; rx_pop = 1; end
            end else if (addr == 4'h2)
                m_dout = {4'b0000, m_ovf, m_unf, tx_n == DEPTH, rx_n == 0};
            else if (addr == 4'h3)
                m_dout = {4'(rx_n), 4'(tx_n)};
            else
                m_dout = 8'h00;
        end
        if (wr && addr == 4'h1) begin
            if (tx_n == DEPTH) set_ovf = 1; else tx_push = 1;
        end
        if (wr && addr == 4'h2) begin
            clr_ovf = data_in[3];
            clr_unf = data_in[2];
        end
        if (tx_n > 0 && ext_tx_ready) void'(txq.pop_front());
        if (tx_push) txq.push_back(data_in);
        if (rx_pop) void'(rxq.pop_front());
        if (rx_n < DEPTH && ext_rx_valid) rxq.push_back(ext_rx_data);
        m_unf = set_unf || (m_unf && !clr_unf);
        m_ovf = set_ovf || (m_ovf && !clr_ovf);
        m_irq = irq_next;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("data_out", data_out, m_dout);
            chk("rd_valid", {7'b0, rd_valid}, {7'b0, m_rv});
            chk("irq", {7'b0, irq}, {7'b0, m_irq});
            chk("ext_rx_ready", {7'b0, ext_rx_ready}, {7'b0, (!rst && rxq.size() < DEPTH)});
            chk("ext_tx_valid", {7'b0, ext_tx_valid}, {7'b0, (txq.size() > 0)});
            if (txq.size() > 0) chk("ext_tx_data", ext_tx_data, txq[0]);
        end
    end

    task automatic rd_reg(input logic [3:0] a, input logic [7:0] exp, input string name);
        @(negedge clk); rd = 1'b1; addr = a;
        @(negedge clk); rd = 1'b0;
        chk(name, data_out, exp);
        chk({name, "_valid"}, {7'b0, rd_valid}, 8'h01);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk); wr = 1'b1; addr = a; data_in = d;
        @(negedge clk); wr = 1'b0;
    endtask

    task automatic ext_push(input logic [7:0] d);
        @(negedge clk); ext_rx_valid = 1'b1; ext_rx_data = d;
    endtask

    initial begin
        logic [7:0] rx_bytes[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        logic [7:0] tx_bytes[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // 1: reset state and idle status
        repeat (2) @(negedge clk);
        chk("rst_ready", {7'b0, ext_rx_ready}, 8'h00);
        chk("rst_dout", data_out, 8'h00);
        rst = 1'b0;
        rd_reg(4'h2, 8'h01, "status_idle");
        @(negedge clk);
        chk("rd_valid_drop", {7'b0, rd_valid}, 8'h00);
        rd_reg(4'h3, 8'h00, "count_idle");
        rd_reg(4'h7, 8'h00, "unmapped");

        // 2: fill RX, drain in order
        for (int i = 0; i < 4; i++) ext_push(rx_bytes[i]);
        @(negedge clk); ext_rx_valid = 1'b0;
        chk("rx_full_ready", {7'b0, ext_rx_ready}, 8'h00);
        chk("irq_rx", {7'b0, irq}, 8'h01);
        rd_reg(4'h3, 8'h40, "count_rx4");
        for (int i = 0; i < 4; i++) rd_reg(4'h0, rx_bytes[i], "rx_data");
        rd_reg(4'h3, 8'h00, "count_rx0");

        // 3: underflow, W1C clear
        rd_reg(4'h0, 8'h00, "rx_unf_data");
        rd_reg(4'h2, 8'h05, "status_unf");
        wr_reg(4'h2, 8'h04);
        rd_reg(4'h2, 8'h01, "status_clr");
        chk("irq_clr", {7'b0, irq}, 8'h00);

        // 4: TX overflow, then drain
        for (int i = 0; i < 5; i++) wr_reg(4'h1, tx_bytes[i]);
        rd_reg(4'h2, 8'h0B, "status_ovf");
        rd_reg(4'h3, 8'h04, "count_tx4");
        @(negedge clk);
        chk("tx_head0", ext_tx_data, 8'h11);
        ext_tx_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("tx_head", ext_tx_data, tx_bytes[i]);
        end
        @(negedge clk);
        chk("tx_drained", {7'b0, ext_tx_valid}, 8'h00);
        ext_tx_ready = 1'b0;
        wr_reg(4'h2, 8'h08);

        // 5: full TX write with same-cycle pop; RX push+pop
        for (int i = 0; i < 4; i++) wr_reg(4'h1, 8'hA0 + 8'(i));
        @(negedge clk); wr = 1'b1; addr = 4'h1; data_in = 8'h99; ext_tx_ready = 1'b1;
        @(negedge clk); wr = 1'b0; ext_tx_ready = 1'b0;
        rd_reg(4'h3, 8'h03, "count_tx3");
        rd_reg(4'h2, 8'h09, "status_ovf2");
        wr_reg(4'h2, 8'h08);
        chk("tx_head_a1", ext_tx_data, 8'hA1);
        ext_tx_ready = 1'b1;
        repeat (4) @(negedge clk);
        ext_tx_ready = 1'b0;
        ext_push(8'h5A);
        ext_push(8'h6B);
        @(negedge clk); ext_rx_data = 8'h7C; rd = 1'b1; addr = 4'h0;
        @(negedge clk); rd = 1'b0; ext_rx_valid = 1'b0;
        chk("rx_pushpop", data_out, 8'h5A);
        rd_reg(4'h3, 8'h20, "count_rx2");
        rd_reg(4'h0, 8'h6B, "rx_6b");
        rd_reg(4'h0, 8'h7C, "rx_7c");

        // 6: rd+wr collision, then reset mid-read
        @(negedge clk); rd = 1'b1; wr = 1'b1; addr = 4'h1; data_in = 8'hE7;
        @(negedge clk); rd = 1'b0; wr = 1'b0;
        chk("collide_valid", {7'b0, rd_valid}, 8'h00);
        chk("collide_tx", ext_tx_data, 8'hE7);
        ext_push(8'h33);
        @(negedge clk); ext_rx_valid = 1'b0; rd = 1'b1; addr = 4'h0;
        @(posedge clk); #1;
        chk("pre_rst_dout", data_out, 8'h33);
        #1; rd = 1'b0; rst = 1'b1;
        #1;
        chk("mid_rst_dout", data_out, 8'h00);
        chk("mid_rst_valid", {7'b0, rd_valid}, 8'h00);
        chk("mid_rst_irq", {7'b0, irq}, 8'h00);
        chk("mid_rst_ready", {7'b0, ext_rx_ready}, 8'h00);
        chk("mid_rst_txv", {7'b0, ext_tx_valid}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {7'b0, ext_rx_ready}, 8'h01);
        rd_reg(4'h3, 8'h00, "count_post_rst");
        rd_reg(4'h2, 8'h01, "status_post_rst");
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
